// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack memory port and
// presents one instruction at a time to the decoder over valid/ready.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        nPC_Sel,
    input  logic        zero,
    input  logic        PCWrite,
    input  logic        PCSel,
    input  logic [31:0] rs_data,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_ERR   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        req_en_q;
    logic [31:0] npc;
    logic [31:0] br_off;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jumps take priority over the branch; jr before jal.
    always_comb begin
        if (PCWrite && PCSel) begin
            npc = rs_data;
        end else if (PCWrite) begin
            npc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (nPC_Sel && zero) begin
            npc = pc_plus4 + br_off;
        end else begin
            npc = pc_plus4;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_FETCH: begin
                if (imem_req && imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    if (npc[1:0] != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        pc_d    = npc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // req_en_q holds the request off for the first cycle after reset is released,
    // so imem_req never depends combinationally on reset_n.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            req_en_q <= 1'b1;
        end
    end

    assign imem_req    = (state_q == S_FETCH) && req_en_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign fetch_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a scripted memory responder pushes each
// returned word to a scoreboard that is popped when the decoder side sees it.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        nPC_Sel;
    logic        zero;
    logic        PCWrite;
    logic        PCSel;
    logic [31:0] rs_data;
    logic        fetch_err;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .nPC_Sel     (nPC_Sel),
        .zero        (zero),
        .PCWrite     (PCWrite),
        .PCSel       (PCSel),
        .rs_data     (rs_data),
        .fetch_err   (fetch_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [31:0] W_NOP  = 32'h0000_0000;
    localparam logic [31:0] W_BEQ  = 32'h1000_FFFC;
    localparam logic [31:0] W_JAL  = 32'h0C00_0C10;
    localparam logic [31:0] W_JR   = 32'h03E0_0008;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Controls outside the consuming HOLD cycle must be ignored, so scramble them.
    task automatic scramble_ctrl();
        nPC_Sel = 1'($urandom);
        zero    = 1'($urandom);
        PCWrite = 1'($urandom);
        PCSel   = 1'($urandom);
        rs_data = $urandom;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        scramble_ctrl();
        repeat (2) @(negedge clk);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_err", fetch_err, 1'b0);
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_instr", instr, 32'd0);
        reset_n = 1'b1;
        #1;
        check("rel_req", imem_req, 1'b0);
        @(negedge clk);
    endtask

    // Called at the negedge of a cycle where a request at addr is expected.
    task automatic fetch_one(input int waits, input logic [31:0] addr, input logic [31:0] word);
        exp_t e;
        sb_q.push_back('{addr, word});
        for (int i = 0; i < waits; i++) begin
            check("wait_req", imem_req, 1'b1);
            check("wait_addr", imem_addr, addr);
            check("wait_valid", instr_valid, 1'b0);
            imem_ack    = 1'b0;
            instr_ready = 1'b1;
            scramble_ctrl();
            @(negedge clk);
        end
        check("req", imem_req, 1'b1);
        check("addr", imem_addr, addr);
        check("valid_low", instr_valid, 1'b0);
        imem_ack    = 1'b1;
        imem_rdata  = word;
        instr_ready = 1'b0;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("valid_high", instr_valid, 1'b1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_instr", instr, e.word);
            check("sb_pc", pc, e.addr);
            check("sb_pc_plus4", pc_plus4, e.addr + 32'd4);
        end
    endtask

    task automatic consume(input logic nsel, input logic z, input logic pw, input logic ps,
                           input logic [31:0] rs);
        check("hold_valid", instr_valid, 1'b1);
        nPC_Sel     = nsel;
        zero        = z;
        PCWrite     = pw;
        PCSel       = ps;
        rs_data     = rs;
        instr_ready = 1'b1;
        imem_ack    = 1'b1;
        imem_rdata  = $urandom;
        @(negedge clk);
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        scramble_ctrl();
    endtask

    initial begin
        reset_n    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        instr_ready = 1'b0;
        scramble_ctrl();

        // Zero-wait sequential fetch
        do_reset();
        fetch_one(0, 32'h3000, 32'hA000_3000);
        consume(0, 0, 0, 0, 32'd0);
        fetch_one(0, 32'h3004, 32'hA000_3004);
        consume(1, 0, 0, 0, 32'd0);
        fetch_one(0, 32'h3008, 32'hA000_3008);

        // Three wait states
        do_reset();
        fetch_one(3, 32'h3000, 32'hB000_0003);

        // beq taken and not taken at 0x3010
        consume(0, 0, 1, 1, 32'h3010);
        fetch_one(0, 32'h3010, W_BEQ);
        consume(1, 1, 0, 0, 32'd0);
        fetch_one(0, 32'h3004, W_JR);
        consume(0, 0, 1, 1, 32'h3010);
        fetch_one(1, 32'h3010, W_BEQ);
        consume(1, 0, 0, 0, 32'd0);
        fetch_one(0, 32'h3014, W_JR);

        // jal at 0x3020; jal must win over a taken branch and ignore rs_data
        consume(0, 0, 1, 1, 32'h3020);
        fetch_one(0, 32'h3020, W_JAL);
        consume(1, 1, 1, 0, 32'h0000_5555);
        fetch_one(0, 32'h0000_3040, W_NOP);

        // pc_plus4 wrap at the top of the address space
        consume(0, 0, 1, 1, 32'hFFFF_FFFC);
        fetch_one(0, 32'hFFFF_FFFC, W_NOP);
        consume(0, 0, 0, 0, 32'd0);
        fetch_one(0, 32'h0000_0000, W_NOP);

        // jr aligned then misaligned
        do_reset();
        fetch_one(0, 32'h3000, W_JR);
        consume(0, 0, 1, 1, 32'h3100);
        fetch_one(0, 32'h3100, W_JR);
        consume(0, 0, 1, 1, 32'h3102);
        check("err_set", fetch_err, 1'b1);
        check("err_valid", instr_valid, 1'b0);
        check("err_pc", pc, 32'h3100);
        for (int i = 0; i < 10; i++) begin
            imem_ack    = 1'b1;
            instr_ready = 1'b1;
            scramble_ctrl();
            check("err_req", imem_req, 1'b0);
            check("err_sticky", fetch_err, 1'b1);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        do_reset();
        check("err_cleared", fetch_err, 1'b0);

        // Stall in HOLD, then reset mid-FETCH with a late ack
        fetch_one(0, 32'h3000, 32'hC0DE_0001);
        for (int i = 0; i < 5; i++) begin
            instr_ready = 1'b0;
            imem_ack    = 1'b1;
            imem_rdata  = $urandom;
            scramble_ctrl();
            @(negedge clk);
            check("stall_instr", instr, 32'hC0DE_0001);
            check("stall_pc", pc, 32'h3000);
            check("stall_req", imem_req, 1'b0);
            check("stall_valid", instr_valid, 1'b1);
        end
        imem_ack = 1'b0;
        consume(0, 0, 0, 0, 32'd0);
        check("pre_rst_req", imem_req, 1'b1);
        check("pre_rst_addr", imem_addr, 32'h3004);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_req", imem_req, 1'b0);
        check("midrst_pc", pc, 32'h3000);
        check("midrst_valid", instr_valid, 1'b0);
        reset_n    = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("late_ack_req", imem_req, 1'b0);
        @(negedge clk);
        imem_ack = 1'b0;
        fetch_one(0, 32'h3000, 32'hC0DE_0002);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
